// File: rtl/blackparrot_fpga_host_axil_master.sv
// Host-side AXI4-Lite initiator: turns one CSR read/write command into one AXI-Lite
// transaction and returns the response on a valid/yumi port. Only one transaction is in flight.
// Optional response timeout is enabled with `define BP_FPGA_HOST_AXIL_TIMEOUT_EN.
module blackparrot_fpga_host_axil_master #(
  parameter int unsigned M_AXIL_ADDR_WIDTH = 64,
  parameter int unsigned M_AXIL_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES    = 1024
) (
  input  logic                           m_axil_aclk,
  input  logic                           m_axil_aresetn,
  input  logic                           cmd_v_i,
  output logic                           cmd_ready_and_o,
  input  logic                           cmd_w_i,
  input  logic [M_AXIL_ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [M_AXIL_DATA_WIDTH-1:0]   cmd_data_i,
  input  logic [M_AXIL_DATA_WIDTH/8-1:0] cmd_wstrb_i,
  output logic                           resp_v_o,
  input  logic                           resp_yumi_i,
  output logic                           resp_w_o,
  output logic [M_AXIL_DATA_WIDTH-1:0]   resp_data_o,
  output logic [1:0]                     resp_err_o,
  output logic                           resp_timeout_o,
  output logic [M_AXIL_ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic                           m_axil_awvalid,
  output logic [2:0]                     m_axil_awprot,
  input  logic                           m_axil_awready,
  output logic [M_AXIL_DATA_WIDTH-1:0]   m_axil_wdata,
  output logic                           m_axil_wvalid,
  output logic [M_AXIL_DATA_WIDTH/8-1:0] m_axil_wstrb,
  input  logic                           m_axil_wready,
  input  logic                           m_axil_bvalid,
  input  logic [1:0]                     m_axil_bresp,
  output logic                           m_axil_bready,
  output logic [M_AXIL_ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic                           m_axil_arvalid,
  output logic [2:0]                     m_axil_arprot,
  input  logic                           m_axil_arready,
  input  logic [M_AXIL_DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic                           m_axil_rvalid,
  input  logic [1:0]                     m_axil_rresp,
  output logic                           m_axil_rready
);

  localparam int unsigned StrbWidth = M_AXIL_DATA_WIDTH / 8;

  typedef enum logic [2:0] {StIdle, StWrite, StReadAr, StReadR, StResp, StDrain} state_e;

  state_e                         state_q;
  logic                           cmd_ready_q;
  logic                           awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [M_AXIL_ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
  logic [M_AXIL_DATA_WIDTH-1:0]   wdata_q;
  logic [StrbWidth-1:0]           wstrb_q;
  logic                           resp_v_q, resp_w_q;
  logic [M_AXIL_DATA_WIDTH-1:0]   resp_data_q;
  logic [1:0]                     resp_err_q;
  logic                           resp_timeout_q;
  logic                           timeout_take;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_pend, w_pend, ar_pend;

  // Handshakes this cycle, and whether a channel is still waiting after this edge
  assign aw_hs   = awvalid_q & m_axil_awready;
  assign w_hs    = wvalid_q & m_axil_wready;
  assign b_hs    = bready_q & m_axil_bvalid;
  assign ar_hs   = arvalid_q & m_axil_arready;
  assign r_hs    = rready_q & m_axil_rvalid;
  assign aw_pend = awvalid_q & ~m_axil_awready;
  assign w_pend  = wvalid_q & ~m_axil_wready;
  assign ar_pend = arvalid_q & ~m_axil_arready;

`ifdef BP_FPGA_HOST_AXIL_TIMEOUT_EN
  localparam int unsigned CntWidth = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CntWidth-1:0] cnt_q;
  logic                waiting;

  assign waiting      = (state_q == StWrite) | (state_q == StReadAr) | (state_q == StReadR);
  // A response handshake in the expiring cycle wins over the timeout
  assign timeout_take = (cnt_q == CntWidth'(TIMEOUT_CYCLES - 1)) &
                        (((state_q == StWrite) & ~b_hs) | (state_q == StReadAr) |
                         ((state_q == StReadR) & ~r_hs));

  // Wait counter and timeout flag for the response currently presented
  always_ff @(posedge m_axil_aclk or negedge m_axil_aresetn) begin
    if (!m_axil_aresetn) begin
      cnt_q          <= '0;
      resp_timeout_q <= 1'b0;
    end else begin
      if (state_q == StIdle) cnt_q <= '0;
      else if (waiting)      cnt_q <= cnt_q + CntWidth'(1);
      if (timeout_take)                              resp_timeout_q <= 1'b1;
      else if ((state_q == StResp) && resp_yumi_i) resp_timeout_q <= 1'b0;
    end
  end
`else
  assign timeout_take   = 1'b0;
  assign resp_timeout_q = 1'b0;
`endif

  // Main FSM with all outputs registered
  always_ff @(posedge m_axil_aclk or negedge m_axil_aresetn) begin
    if (!m_axil_aresetn) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      resp_v_q    <= 1'b0;
      resp_w_q    <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 2'b00;
    end else begin
      if (aw_hs) awvalid_q <= 1'b0;
      if (w_hs)  wvalid_q  <= 1'b0;
      if (ar_hs) arvalid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cmd_ready_q <= 1'b1;
          if (cmd_v_i && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            if (cmd_w_i) begin
              awaddr_q  <= cmd_addr_i;
              wdata_q   <= cmd_data_i;
              wstrb_q   <= cmd_wstrb_i;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= StWrite;
            end else begin
              araddr_q  <= cmd_addr_i;
              arvalid_q <= 1'b1;
              state_q   <= StReadAr;
            end
          end
        end
        StWrite: begin
          if (b_hs) begin
            bready_q    <= 1'b0;
            resp_v_q    <= 1'b1;
            resp_w_q    <= 1'b1;
            resp_data_q <= '0;
            resp_err_q  <= m_axil_bresp;
            state_q     <= StResp;
          end else if (timeout_take) begin
            bready_q    <= 1'b0;
            resp_v_q    <= 1'b1;
            resp_w_q    <= 1'b1;
            resp_data_q <= '0;
            resp_err_q  <= 2'b10;
            state_q     <= StResp;
          end else if (!aw_pend && !w_pend) begin
            bready_q <= 1'b1;
          end
        end
        StReadAr: begin
          if (timeout_take) begin
            resp_v_q    <= 1'b1;
            resp_w_q    <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= 2'b10;
            state_q     <= StResp;
          end else if (ar_hs) begin
            rready_q <= 1'b1;
            state_q  <= StReadR;
          end
        end
        StReadR: begin
          if (r_hs || timeout_take) begin
            rready_q    <= 1'b0;
            resp_v_q    <= 1'b1;
            resp_w_q    <= 1'b0;
            resp_data_q <= r_hs ? m_axil_rdata : '0;
            resp_err_q  <= r_hs ? m_axil_rresp : 2'b10;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (resp_yumi_i) begin
            resp_v_q <= 1'b0;
            if (resp_timeout_q) begin
              state_q <= StDrain;
            end else begin
              cmd_ready_q <= 1'b1;
              state_q     <= StIdle;
            end
          end
        end
        StDrain: begin
          // Finish the abandoned transaction and discard its late response
          if (resp_w_q) begin
            if (!aw_pend && !w_pend) bready_q <= 1'b1;
            if (b_hs) begin
              bready_q    <= 1'b0;
              cmd_ready_q <= 1'b1;
              state_q     <= StIdle;
            end
          end else begin
            if (!ar_pend) rready_q <= 1'b1;
            if (r_hs) begin
              rready_q    <= 1'b0;
              cmd_ready_q <= 1'b1;
              state_q     <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready_and_o = cmd_ready_q;
  assign resp_v_o        = resp_v_q;
  assign resp_w_o        = resp_w_q;
  assign resp_data_o     = resp_data_q;
  assign resp_err_o      = resp_err_q;
  assign resp_timeout_o  = resp_timeout_q;
  assign m_axil_awaddr   = awaddr_q;
  assign m_axil_awvalid  = awvalid_q;
  assign m_axil_awprot   = 3'b000;
  assign m_axil_wdata    = wdata_q;
  assign m_axil_wvalid   = wvalid_q;
  assign m_axil_wstrb    = wstrb_q;
  assign m_axil_bready   = bready_q;
  assign m_axil_araddr   = araddr_q;
  assign m_axil_arvalid  = arvalid_q;
  assign m_axil_arprot   = 3'b000;
  assign m_axil_rready   = rready_q;

endmodule

// File: tb/tb_blackparrot_fpga_host_axil_master.sv
// Bench for the host AXI-Lite initiator: scripted subordinate plus a response scoreboard.
module tb_blackparrot_fpga_host_axil_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_v = 1'b0, cmd_ready, cmd_w = 1'b0;
  logic [63:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        resp_v, resp_yumi = 1'b0, resp_w, resp_timeout;
  logic [31:0] resp_data;
  logic [1:0]  resp_err;
  logic [63:0] awaddr, araddr;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata = '0;
  logic [3:0]  wstrb;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;

  typedef struct packed {logic w; logic [31:0] data; logic [1:0] err; logic to;} exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, resp_cnt = 0;

  always #5 clk = ~clk;

  blackparrot_fpga_host_axil_master #(
    .M_AXIL_ADDR_WIDTH(64),
    .M_AXIL_DATA_WIDTH(32),
    .TIMEOUT_CYCLES   (16)
  ) dut (
    .m_axil_aclk    (clk),
    .m_axil_aresetn (rst_n),
    .cmd_v_i        (cmd_v),
    .cmd_ready_and_o(cmd_ready),
    .cmd_w_i        (cmd_w),
    .cmd_addr_i     (cmd_addr),
    .cmd_data_i     (cmd_data),
    .cmd_wstrb_i    (cmd_wstrb),
    .resp_v_o       (resp_v),
    .resp_yumi_i    (resp_yumi),
    .resp_w_o       (resp_w),
    .resp_data_o    (resp_data),
    .resp_err_o     (resp_err),
    .resp_timeout_o (resp_timeout),
    .m_axil_awaddr  (awaddr),
    .m_axil_awvalid (awvalid),
    .m_axil_awprot  (awprot),
    .m_axil_awready (awready),
    .m_axil_wdata   (wdata),
    .m_axil_wvalid  (wvalid),
    .m_axil_wstrb   (wstrb),
    .m_axil_wready  (wready),
    .m_axil_bvalid  (bvalid),
    .m_axil_bresp   (bresp),
    .m_axil_bready  (bready),
    .m_axil_araddr  (araddr),
    .m_axil_arvalid (arvalid),
    .m_axil_arprot  (arprot),
    .m_axil_arready (arready),
    .m_axil_rdata   (rdata),
    .m_axil_rvalid  (rvalid),
    .m_axil_rresp   (rresp),
    .m_axil_rready  (rready)
  );

  // Handshake counters
  always @(posedge clk) begin
    if (awvalid && awready) aw_cnt <= aw_cnt + 1;
    if (wvalid && wready)   w_cnt <= w_cnt + 1;
    if (bvalid && bready)   b_cnt <= b_cnt + 1;
    if (arvalid && arready) ar_cnt <= ar_cnt + 1;
    if (rvalid && rready)   r_cnt <= r_cnt + 1;
    if (resp_v && resp_yumi) resp_cnt <= resp_cnt + 1;
  end

  // Issue one command; returns on the negedge after its handshake
  task automatic send_cmd(input logic w, input logic [63:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    int i;
    cmd_v = 1'b1; cmd_w = w; cmd_addr = a; cmd_data = d; cmd_wstrb = s;
    for (i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
    total++;
    if (!cmd_ready) begin
      bad++; $display("FAIL cmd_accept: ready=%0b required 1", cmd_ready);
    end
    @(negedge clk);
    cmd_v = 1'b0;
  endtask

  task automatic sub_aw(input int lat, input logic [63:0] a);
    int i;
    repeat (lat) @(negedge clk);
    awready = 1'b1;
    for (i = 0; i < 100 && !awvalid; i++) @(negedge clk);
    total++;
    if (!awvalid || awaddr !== a || awprot !== 3'b000) begin
      bad++; $display("FAIL aw_chan: valid=%0b addr=%h required addr %h", awvalid, awaddr, a);
    end
    @(negedge clk);
    awready = 1'b0;
  endtask

  task automatic sub_w(input int lat, input logic [31:0] d, input logic [3:0] s);
    int i;
    repeat (lat) @(negedge clk);
    wready = 1'b1;
    for (i = 0; i < 100 && !wvalid; i++) @(negedge clk);
    total++;
    if (!wvalid || wdata !== d || wstrb !== s) begin
      bad++; $display("FAIL w_chan: valid=%0b data=%h strb=%h required %h %h",
                      wvalid, wdata, wstrb, d, s);
    end
    @(negedge clk);
    wready = 1'b0;
  endtask

  task automatic sub_b(input int lat, input logic [1:0] r);
    int i;
    repeat (lat) @(negedge clk);
    bvalid = 1'b1; bresp = r;
    for (i = 0; i < 100 && !bready; i++) @(negedge clk);
    total++;
    if (!bready) begin
      bad++; $display("FAIL b_wait: bready=0 required 1");
    end
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
  endtask

  task automatic sub_ar(input int lat, input logic [63:0] a);
    int i;
    repeat (lat) @(negedge clk);
    arready = 1'b1;
    for (i = 0; i < 100 && !arvalid; i++) @(negedge clk);
    total++;
    if (!arvalid || araddr !== a || arprot !== 3'b000) begin
      bad++; $display("FAIL ar_chan: valid=%0b addr=%h required addr %h", arvalid, araddr, a);
    end
    @(negedge clk);
    arready = 1'b0;
  endtask

  task automatic sub_r(input int lat, input logic [31:0] d, input logic [1:0] r);
    int i;
    repeat (lat) @(negedge clk);
    rvalid = 1'b1; rdata = d; rresp = r;
    for (i = 0; i < 200 && !rready; i++) @(negedge clk);
    total++;
    if (!rready) begin
      bad++; $display("FAIL r_wait: rready=0 required 1");
    end
    @(negedge clk);
    rvalid = 1'b0; rdata = '0; rresp = 2'b00;
  endtask

  // Wait for a response, compare with the scoreboard head, optionally stall, then consume
  task automatic get_resp(input int hold);
    int i;
    exp_t e;
    for (i = 0; i < 200 && !resp_v; i++) @(negedge clk);
    total++;
    if (!resp_v || exp_q.size() == 0) begin
      bad++; $display("FAIL resp_wait: resp_v=%0b queued=%0d", resp_v, exp_q.size());
      return;
    end
    e = exp_q.pop_front();
    total++;
    if ({resp_w, resp_data, resp_err, resp_timeout} !== e) begin
      bad++; $display("FAIL resp_fields: got w=%0b d=%h e=%0d t=%0b required w=%0b d=%h e=%0d t=%0b",
                      resp_w, resp_data, resp_err, resp_timeout, e.w, e.data, e.err, e.to);
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      total++;
      if (!resp_v || {resp_w, resp_data, resp_err, resp_timeout} !== e || cmd_ready !== 1'b0) begin
        bad++; $display("FAIL resp_hold: cycle %0d v=%0b d=%h cmd_ready=%0b required v=1 d=%h ready=0",
                        k, resp_v, resp_data, cmd_ready, e.data);
      end
    end
    resp_yumi = 1'b1;
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++; $display("FAIL yumi_ready: cmd_ready=%0b required 0", cmd_ready);
    end
    @(negedge clk);
    resp_yumi = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({cmd_ready, awvalid, wvalid, bready, arvalid, rready, resp_v} !== 7'b0 ||
        {awaddr, araddr, wdata, wstrb, resp_data, resp_err} !== '0) begin
      bad++; $display("FAIL reset_outputs: some output nonzero while reset asserted");
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: cmd_ready=%0b required 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    int aw0 = aw_cnt, w0 = w_cnt;
    exp_q.push_back('{w: 1'b1, data: 32'h0, err: 2'b00, to: 1'b0});
    send_cmd(1'b1, 64'h0, 32'hDEAD_BEEF, 4'hF);
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++; $display("FAIL busy_ready: cmd_ready=%0b required 0", cmd_ready);
    end
    fork
      sub_aw(3, 64'h0);
      sub_w(0, 32'hDEAD_BEEF, 4'hF);
    join
    sub_b(0, 2'b00);
    get_resp(0);
    total++;
    if (aw_cnt - aw0 != 1 || w_cnt - w0 != 1) begin
      bad++; $display("FAIL write_beats: aw=%0d w=%0d required 1 1", aw_cnt - aw0, w_cnt - w0);
    end
  endtask

  task automatic test_read();
    exp_q.push_back('{w: 1'b0, data: 32'h5, err: 2'b00, to: 1'b0});
    send_cmd(1'b0, 64'h8, 32'h0, 4'h0);
    sub_ar(0, 64'h8);
    sub_r(2, 32'h5, 2'b00);
    get_resp(0);
  endtask

  task automatic test_b_early();
    int b0 = b_cnt, r0;
    exp_q.push_back('{w: 1'b1, data: 32'h0, err: 2'b00, to: 1'b0});
    send_cmd(1'b1, 64'h10, 32'h1234, 4'h3);
    sub_aw(0, 64'h10);
    bvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (bready !== 1'b0 || wvalid !== 1'b1) begin
        bad++; $display("FAIL b_early: bready=%0b wvalid=%0b required 0 1", bready, wvalid);
      end
    end
    sub_w(0, 32'h1234, 4'h3);
    sub_b(0, 2'b00);
    get_resp(0);
    r0 = resp_cnt;
    repeat (4) @(negedge clk);
    total++;
    if (b_cnt - b0 != 1 || resp_cnt != r0 || resp_v !== 1'b0) begin
      bad++; $display("FAIL b_single: b=%0d resp_v=%0b required 1 0", b_cnt - b0, resp_v);
    end
  endtask

  task automatic test_hold();
    int ar0;
    exp_q.push_back('{w: 1'b0, data: 32'hA5A5_0F0F, err: 2'b00, to: 1'b0});
    send_cmd(1'b0, 64'h20, 32'h0, 4'h0);
    sub_ar(0, 64'h20);
    sub_r(0, 32'hA5A5_0F0F, 2'b00);
    cmd_v = 1'b1; cmd_w = 1'b0; cmd_addr = 64'h40;
    get_resp(10);
    cmd_v = 1'b0;
    ar0 = ar_cnt;
    repeat (3) @(negedge clk);
    total++;
    if (arvalid !== 1'b0 || ar_cnt != ar0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL hold_no_cmd: arvalid=%0b ready=%0b required 0 1", arvalid, cmd_ready);
    end
  endtask

  task automatic test_err();
    exp_q.push_back('{w: 1'b1, data: 32'h0, err: 2'b10, to: 1'b0});
    send_cmd(1'b1, 64'h4, 32'hCAFE, 4'h1);
    fork
      sub_aw(0, 64'h4);
      sub_w(1, 32'hCAFE, 4'h1);
    join
    sub_b(1, 2'b10);
    get_resp(0);
    exp_q.push_back('{w: 1'b0, data: 32'h9, err: 2'b11, to: 1'b0});
    send_cmd(1'b0, 64'hC, 32'h0, 4'h0);
    sub_ar(2, 64'hC);
    sub_r(0, 32'h9, 2'b11);
    get_resp(0);
  endtask

  task automatic test_reset_mid();
    int r0 = resp_cnt;
    send_cmd(1'b0, 64'h30, 32'h0, 4'h0);
    sub_ar(0, 64'h30);
    total++;
    if (rready !== 1'b1) begin
      bad++; $display("FAIL mid_rready: rready=%0b required 1", rready);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({arvalid, rready, resp_v, cmd_ready} !== 4'b0) begin
      bad++; $display("FAIL mid_reset: ar=%0b r=%0b v=%0b rdy=%0b required 0",
                      arvalid, rready, resp_v, cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || resp_v !== 1'b0 || resp_cnt != r0) begin
      bad++; $display("FAIL mid_after: ready=%0b resp_v=%0b required 1 0", cmd_ready, resp_v);
    end
  endtask

`ifdef BP_FPGA_HOST_AXIL_TIMEOUT_EN
  task automatic test_timeout();
    int r0;
    exp_q.push_back('{w: 1'b0, data: 32'h0, err: 2'b10, to: 1'b1});
    send_cmd(1'b0, 64'h50, 32'h0, 4'h0);
    sub_ar(0, 64'h50);
    get_resp(0);
    r0 = resp_cnt;
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++; $display("FAIL drain_ready: cmd_ready=%0b required 0", cmd_ready);
    end
    sub_r(20, 32'h77, 2'b00);
    total++;
    if (cmd_ready !== 1'b1 || resp_v !== 1'b0 || resp_cnt != r0) begin
      bad++; $display("FAIL drain_done: ready=%0b resp_v=%0b required 1 0", cmd_ready, resp_v);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_b_early();
    test_hold();
    test_err();
    test_reset_mid();
`ifdef BP_FPGA_HOST_AXIL_TIMEOUT_EN
    test_timeout();
`endif
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_left: %0d entries required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
